// File: rtl/vend_ctrl.sv
// Coin-operated drink dispenser sequencer: synchronizes and debounces the two coin
// buttons, accumulates half-unit credit, and holds drink/change outputs for a fixed time.
module vend_ctrl #(
  parameter int PRICE           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       in1,
  input  logic       in0_5,
  output logic [3:0] credit,
  output logic [3:0] change_amt,
  output logic       drink,
  output logic       change,
  output logic       busy
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        PRICE_Q   = 4'(PRICE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2
  } state_t;

  // bit 1 = 1.0-unit button, bit 0 = 0.5-unit button
  logic [1:0]      raw_btn;
  logic [1:0]      sync_p0;
  logic [1:0]      sync_p1;
  logic [1:0]      level;
  logic [1:0]      coin_ev;
  logic [DB_W-1:0] db_cnt [2];

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [3:0]        sum;

  assign raw_btn = {in1, in0_5};

  // Stage p0/p1: two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= raw_btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the level flips once the synced input has disagreed for DEBOUNCE_CYCLES
  // consecutive cycles and then still disagrees; only a 0->1 flip emits a coin pulse.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      level   <= 2'b00;
      coin_ev <= 2'b00;
      for (int b = 0; b < 2; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        coin_ev[b] <= 1'b0;
        if (sync_p1[b] == level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_MAX) begin
          level[b]   <= sync_p1[b];
          coin_ev[b] <= sync_p1[b];
          db_cnt[b]  <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Max sum is PRICE+2 <= 15, so 4 bits never overflow.
  always_comb begin
    sum = credit + {2'b00, coin_ev[1], 1'b0} + {3'b000, coin_ev[0]};
  end

  // Controller: all outputs registered, updated together on VEND entry and exit
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      credit     <= 4'd0;
      change_amt <= 4'd0;
      drink      <= 1'b0;
      change     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (sum >= PRICE_Q) begin
            state      <= VEND;
            credit     <= sum;
            change_amt <= sum - PRICE_Q;
            drink      <= 1'b1;
            change     <= (sum > PRICE_Q);
            busy       <= 1'b1;
            hold_cnt   <= HOLD_LOAD;
          end else if (sum != 4'd0) begin
            state  <= COLLECT;
            credit <= sum;
          end
        end
        VEND: begin
          // Coin events arriving here, including on the exit edge, are dropped.
          if (hold_cnt == '0) begin
            state      <= IDLE;
            credit     <= 4'd0;
            change_amt <= 4'd0;
            drink      <= 1'b0;
            change     <= 1'b0;
            busy       <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          hold_cnt   <= '0;
          credit     <= 4'd0;
          change_amt <= 4'd0;
          drink      <= 1'b0;
          change     <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with PRICE=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_vend_ctrl;

  logic       clk_50MHz;
  logic       reset;
  logic       in1;
  logic       in0_5;
  logic [3:0] credit;
  logic [3:0] change_amt;
  logic       drink;
  logic       change;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       i1;
    logic       i05;
    int         n;
    logic [3:0] cr;
    logic [3:0] ca;
    logic       dr;
    logic       ch;
    logic       bz;
  } vec_t;

  vec_t vecs[$];

  vend_ctrl #(
    .PRICE          (5),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .in1       (in1),
    .in0_5     (in0_5),
    .credit    (credit),
    .change_amt(change_amt),
    .drink     (drink),
    .change    (change),
    .busy      (busy)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = {credit, change_amt, drink, change, busy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got credit=%0d change_amt=%0d drink=%b change=%b busy=%b, expected credit=%0d change_amt=%0d drink=%b change=%b busy=%b",
               name, got[10:7], got[6:3], got[2], got[1], got[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic i1, input logic i05, input int n, input logic [3:0] cr,
                     input logic [3:0] ca, input logic dr, input logic ch, input logic bz);
    vec_t v;
    v.i1 = i1; v.i05 = i05; v.n = n;
    v.cr = cr; v.ca = ca; v.dr = dr; v.ch = ch; v.bz = bz;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1;
    in1   = 1'b0;
    in0_5 = 1'b0;

    // in1, in1, in0_5 -> exact price, no change
    add(0, 0, 3, 0, 0, 0, 0, 0);
    add(1, 0, 7, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 0, 0);
    add(0, 0, 8, 2, 0, 0, 0, 0);
    add(1, 0, 7, 2, 0, 0, 0, 0);
    add(1, 0, 1, 4, 0, 0, 0, 0);
    add(0, 0, 8, 4, 0, 0, 0, 0);
    add(0, 1, 7, 4, 0, 0, 0, 0);
    add(0, 1, 1, 5, 0, 1, 0, 1);
    add(0, 0, 9, 5, 0, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // in1 x3 -> overpay by one half-unit
    add(1, 0, 7, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 0, 0);
    add(0, 0, 8, 2, 0, 0, 0, 0);
    add(1, 0, 7, 2, 0, 0, 0, 0);
    add(1, 0, 1, 4, 0, 0, 0, 0);
    add(0, 0, 8, 4, 0, 0, 0, 0);
    add(1, 0, 7, 4, 0, 0, 0, 0);
    add(1, 0, 1, 6, 1, 1, 1, 1);
    add(0, 0, 9, 6, 1, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // 3-cycle glitch and 1-0-1-0 bounce are rejected
    add(1, 0, 3, 0, 0, 0, 0, 0);
    add(0, 0, 8, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 8, 0, 0, 0, 0, 0);
    add(1, 0, 7, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 0, 0);
    add(0, 0, 8, 2, 0, 0, 0, 0);
    add(1, 0, 7, 2, 0, 0, 0, 0);
    add(1, 0, 1, 4, 0, 0, 0, 0);
    add(0, 0, 8, 4, 0, 0, 0, 0);
    // both buttons together with credit 4 (held 5 raw samples, the minimum accepted)
    add(1, 1, 5, 4, 0, 0, 0, 0);
    add(0, 0, 2, 4, 0, 0, 0, 0);
    add(0, 0, 1, 7, 2, 1, 1, 1);
    add(0, 0, 2, 7, 2, 1, 1, 1);
    // in1 pressed during VEND: its event lands on the exit edge and is dropped
    add(1, 0, 7, 7, 2, 1, 1, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 8, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk_50MHz);
    chk("reset_hold", 11'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      in1   = vecs[i].i1;
      in0_5 = vecs[i].i05;
      repeat (vecs[i].n) @(negedge clk_50MHz);
      chk($sformatf("vec%0d", i),
          {vecs[i].cr, vecs[i].ca, vecs[i].dr, vecs[i].ch, vecs[i].bz});
    end

    // Short mid-cycle reset clears outputs before the next edge
    in1 = 1'b1;
    repeat (8) @(negedge clk_50MHz);
    in1 = 1'b0;
    chk("mid_pre", {4'd2, 4'd0, 3'b000});
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk("mid_rst", 11'd0);
    repeat (3) @(negedge clk_50MHz);

    // Reach VEND with credit 6, then reset during its fifth cycle
    in1 = 1'b1; in0_5 = 1'b1;
    repeat (8) @(negedge clk_50MHz);
    in1 = 1'b0; in0_5 = 1'b0;
    chk("v_c3", {4'd3, 4'd0, 3'b000});
    repeat (8) @(negedge clk_50MHz);
    in1 = 1'b1; in0_5 = 1'b1;
    repeat (8) @(negedge clk_50MHz);
    in1 = 1'b0; in0_5 = 1'b0;
    chk("v_entry", {4'd6, 4'd1, 3'b111});
    repeat (4) @(negedge clk_50MHz);
    chk("v_cyc5", {4'd6, 4'd1, 3'b111});
    in1 = 1'b1;
    #2 reset = 1'b1;
    #1 chk("v_rst", 11'd0);
    #1 reset = 1'b0;
    // in1 held across release: first sampled at edge E, credit updates at E+7
    @(negedge clk_50MHz);
    repeat (6) @(negedge clk_50MHz);
    chk("hold_pre", 11'd0);
    @(negedge clk_50MHz);
    chk("hold_post", {4'd2, 4'd0, 3'b000});
    in1 = 1'b0;
    repeat (8) @(negedge clk_50MHz);
    chk("hold_end", {4'd2, 4'd0, 3'b000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
